// File: rtl/freq_meter.sv
// Measures period and high time of a slow asynchronous input in clk cycles.
// Reports one result per input period and pulses timeout when the input stalls.
module freq_meter #(
    parameter int CNT_W       = 24,
    parameter int TIMEOUT     = 1000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic             locked
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       hcnt_q, hcnt_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic [CNT_W-1:0]       high_q, high_d;
    logic                   valid_q, valid_d;
    logic                   timeout_q, timeout_d;
    logic                   locked_q, locked_d;
    logic                   s;
    logic                   rise;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev_q;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], sig_in};
        prev_d    = s;
        state_d   = state_q;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;

        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
            hcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARM;
                    cnt_d   = '0;
                    hcnt_d  = '0;
                end
                ARM: begin
                    // A rise takes priority over an expiring count
                    if (rise) begin
                        state_d = MEASURE;
                        cnt_d   = ONE;
                        hcnt_d  = ONE;
                    end else if (cnt_q == TIMEOUT_C) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        hcnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_d = cnt_q;
                        high_d   = hcnt_q;
                        valid_d  = 1'b1;
                        cnt_d    = ONE;
                        hcnt_d   = ONE;
                    end else if (cnt_q == TIMEOUT_C) begin
                        timeout_d = 1'b1;
                        state_d   = ARM;
                        cnt_d     = '0;
                        hcnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                        if (s) begin
                            hcnt_d = hcnt_q + ONE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    hcnt_d  = '0;
                end
            endcase
        end

        locked_d = (state_d == MEASURE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            locked_q  <= locked_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;
    assign locked    = locked_q;

endmodule
